conv_stream_scheduler: RTL and testbench

- Sequences one frame of raster-order pixels into the convolution wrapper's line-buffer/conv datapath.
- Accepts pixels over a valid/ready stream and produces the wrapper's we, wr_addr, eol and ready controls.
- Tracks row/column position to flag valid output windows, and emits out_valid/out_last aligned to the conv result after a fixed pipeline latency.
- Sits between the input DMA/stream source and the convolution wrapper instance.

---
 rtl/conv_pkg.sv | 29 ++
 rtl/conv_valid_delay.sv | 36 +++
 rtl/conv_stream_scheduler.sv | 155 +++++++++++++++
 tb/tb_conv_stream_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution stream scheduler.
// The window-count helpers take the image and kernel sizes as arguments
// because those are parameters of the instance.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Number of window positions across one row.
    function automatic int num_win_cols(input int img_width, input int kernel_width);
        return img_width - kernel_width + 1;
    endfunction

    // Number of window positions down one column.
    function automatic int num_win_rows(input int img_height, input int kernel_height);
        return img_height - kernel_height + 1;
    endfunction

    // Total number of results produced per frame.
    function automatic int num_windows(input int img_width, input int img_height,
                                       input int kernel_width, input int kernel_height);
        return num_win_cols(img_width, kernel_width) * num_win_rows(img_height, kernel_height);
    endfunction

endpackage

// File: rtl/conv_valid_delay.sv
// Fixed-latency delay line for the (valid, last) pair that tracks a window
// through the convolution datapath. Cleared asynchronously so that a reset
// drops every result still in flight.
module conv_valid_delay #(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last
);

    logic [LATENCY-1:0] valid_sr;
    logic [LATENCY-1:0] last_sr;

    // Shift both flags one stage per cycle; stage 0 takes the new input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_sr <= '0;
            last_sr  <= '0;
        end else begin
            valid_sr[0] <= in_valid;
            last_sr[0]  <= in_last;
            for (int i = 1; i < LATENCY; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                last_sr[i]  <= last_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[LATENCY-1];
    assign out_last  = last_sr[LATENCY-1];

endmodule

// File: rtl/conv_stream_scheduler.sv
// Frame sequencer between a raster pixel stream and the convolution wrapper.
// Handshake: a pixel transfers on a rising edge where s_valid and s_ready are
// both high; s_ready depends only on the state (high in FILL and STREAM), the
// source may drop s_valid at any time, and there is no downstream stall.
module conv_stream_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH     = 64,
    parameter int IMG_HEIGHT    = 64,
    parameter int KERNEL_WIDTH  = 3,
    parameter int KERNEL_HEIGHT = 3,
    parameter int ADDR_WIDTH    = 14,
    parameter int CONV_LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  cw_we,
    output logic [ADDR_WIDTH-1:0] cw_wr_addr,
    output logic                  cw_eol,
    output logic                  cw_ready,
    output logic                  out_valid,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);

    localparam int ROW_W   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int DRAIN_W = $clog2(CONV_LATENCY + 2);
    // Last FILL row; unused when a single-row kernel skips FILL.
    localparam int FILL_LAST_ROW = (KERNEL_HEIGHT >= 2) ? KERNEL_HEIGHT - 2 : 0;

    localparam logic [ADDR_WIDTH-1:0] COL_LAST  = ADDR_WIDTH'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0]      ROW_FILL  = ROW_W'(FILL_LAST_ROW);
    // Drain holds one cycle past the last result so done trails out_last.
    localparam logic [DRAIN_W-1:0]    DRAIN_END = DRAIN_W'(CONV_LATENCY + 1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] col;
    logic [ROW_W-1:0]      row;
    logic [DRAIN_W-1:0]    drain_cnt;
    logic                  accept;
    logic                  col_end;
    logic                  frame_end;
    logic                  in_window;
    logic                  win_last;

    assign s_ready   = (state == FILL) || (state == STREAM);
    assign accept    = s_valid && s_ready;
    assign col_end   = (col == COL_LAST);
    assign frame_end = col_end && (row == ROW_LAST);
    assign in_window = (int'(row) >= KERNEL_HEIGHT - 1) && (int'(col) >= KERNEL_WIDTH - 1);
    assign busy      = (state != IDLE);
    assign done      = (state == DRAIN) && (drain_cnt == DRAIN_END);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: FILL primes the line buffer, STREAM produces windows.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (KERNEL_HEIGHT == 1) ? STREAM : FILL;
                end
            end
            FILL: begin
                if (accept && col_end && (row == ROW_FILL)) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (accept && frame_end) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_END) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Raster position of the next pixel, plus the drain cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col       <= '0;
            row       <= '0;
            drain_cnt <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                col <= '0;
                row <= '0;
            end else if (accept) begin
                if (col_end) begin
                    col <= '0;
                    if (!frame_end) begin
                        row <= row + ROW_W'(1);
                    end
                end else begin
                    col <= col + ADDR_WIDTH'(1);
                end
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + DRAIN_W'(1);
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    // Wrapper controls, registered one cycle after the accepting edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cw_we      <= 1'b0;
            cw_wr_addr <= '0;
            cw_eol     <= 1'b0;
            cw_ready   <= 1'b0;
            win_last   <= 1'b0;
        end else begin
            cw_we      <= accept;
            cw_wr_addr <= accept ? col : '0;
            cw_eol     <= accept && col_end;
            cw_ready   <= accept && in_window;
            win_last   <= accept && frame_end;
        end
    end

    conv_valid_delay #(
        .LATENCY (CONV_LATENCY)
    ) u_valid_delay (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (cw_ready),
        .in_last   (win_last),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_conv_stream_scheduler.sv
// Bench for conv_stream_scheduler: three instances (5x4/K3x3/L2, 3x3/K3x3/L2,
// 4x2/K1x1/L1) share the stimulus; one is observed at a time. Expected traces
// come from a pixel-index model of the frame timing rules.
module tb_conv_stream_scheduler;
  import conv_pkg::*;

  localparam int AW   = 14;
  localparam int MAXC = 400;

  typedef struct packed {
    logic          s_ready;
    logic          we;
    logic [AW-1:0] addr;
    logic          eol;
    logic          rdy;
    logic          ov;
    logic          ol;
    logic          busy;
    logic          done;
  } obs_t;

  typedef struct {
    int mode;       // 0 continuous, 1 toggle, 2 random
    int mid_start;  // cycle to pulse an ignored start, -1 for none
    bit restart;    // pulse start in the done cycle, next frame follows at once
    int exp_we;
    int exp_eol;
    int exp_res;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, s_valid;
  int   sel;
  int   checks = 0;
  int   failures = 0;

  logic          a_sr, a_we, a_eol, a_rdy, a_ov, a_ol, a_busy, a_done;
  logic [AW-1:0] a_addr;
  logic [1:0]    a_dbg;
  logic          b_sr, b_we, b_eol, b_rdy, b_ov, b_ol, b_busy, b_done;
  logic [AW-1:0] b_addr;
  logic [1:0]    b_dbg;
  logic          c_sr, c_we, c_eol, c_rdy, c_ov, c_ol, c_busy, c_done;
  logic [AW-1:0] c_addr;
  logic [1:0]    c_dbg;
  obs_t          obs_a, obs_b, obs_c, obs;
  logic [1:0]    dbg;

  conv_stream_scheduler #(.IMG_WIDTH(5), .IMG_HEIGHT(4), .KERNEL_WIDTH(3), .KERNEL_HEIGHT(3),
                          .ADDR_WIDTH(AW), .CONV_LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_ready(a_sr),
    .cw_we(a_we), .cw_wr_addr(a_addr), .cw_eol(a_eol), .cw_ready(a_rdy),
    .out_valid(a_ov), .out_last(a_ol), .busy(a_busy), .done(a_done), .dbg_state(a_dbg));

  conv_stream_scheduler #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .KERNEL_WIDTH(3), .KERNEL_HEIGHT(3),
                          .ADDR_WIDTH(AW), .CONV_LATENCY(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_ready(b_sr),
    .cw_we(b_we), .cw_wr_addr(b_addr), .cw_eol(b_eol), .cw_ready(b_rdy),
    .out_valid(b_ov), .out_last(b_ol), .busy(b_busy), .done(b_done), .dbg_state(b_dbg));

  conv_stream_scheduler #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .KERNEL_WIDTH(1), .KERNEL_HEIGHT(1),
                          .ADDR_WIDTH(AW), .CONV_LATENCY(1)) dut_c (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_ready(c_sr),
    .cw_we(c_we), .cw_wr_addr(c_addr), .cw_eol(c_eol), .cw_ready(c_rdy),
    .out_valid(c_ov), .out_last(c_ol), .busy(c_busy), .done(c_done), .dbg_state(c_dbg));

  assign obs_a = {a_sr, a_we, a_addr, a_eol, a_rdy, a_ov, a_ol, a_busy, a_done};
  assign obs_b = {b_sr, b_we, b_addr, b_eol, b_rdy, b_ov, b_ol, b_busy, b_done};
  assign obs_c = {c_sr, c_we, c_addr, c_eol, c_rdy, c_ov, c_ol, c_busy, c_done};
  assign obs   = (sel == 0) ? obs_a : (sel == 1) ? obs_b : obs_c;
  assign dbg   = (sel == 0) ? a_dbg : (sel == 1) ? b_dbg : c_dbg;

  // scoreboard state
  obs_t          exp_tr[MAXC];
  logic          sv[MAXC];
  logic [AW-1:0] exp_q[$];
  int            cd;

  task automatic check_obs(input string name, input int cyc, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got sr=%b we=%b addr=%0d eol=%b rdy=%b ov=%b ol=%b busy=%b done=%b want sr=%b we=%b addr=%0d eol=%b rdy=%b ov=%b ol=%b busy=%b done=%b",
               name, cyc, act.s_ready, act.we, act.addr, act.eol, act.rdy, act.ov, act.ol, act.busy, act.done,
               exp.s_ready, exp.we, exp.addr, exp.eol, exp.rdy, exp.ov, exp.ol, exp.busy, exp.done);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Reference model: pixel k accepted in cycle c shows on the wrapper
  // controls in c+1 and as a result in c+1+lat; done follows the last result.
  task automatic build_model(input int w, input int h, input int kw, input int kh,
                             input int lat, input int mode);
    int k, n, cf, pc, pr;
    n = w * h;
    k = 0;
    cf = 0;
    for (int c = 0; c < MAXC; c++) begin
      exp_tr[c] = '0;
      case (mode)
        0:       sv[c] = 1'b1;
        1:       sv[c] = (c % 2 == 0);
        default: sv[c] = (c > 200) ? 1'b1 : ($urandom_range(0, 2) != 0);
      endcase
    end
    exp_q.delete();
    for (int c = 0; c < MAXC - lat - 3 && k < n; c++) begin
      exp_tr[c].s_ready = 1'b1;
      if (sv[c]) begin
        pc = k % w;
        pr = k / w;
        exp_tr[c+1].we   = 1'b1;
        exp_tr[c+1].addr = AW'(pc);
        exp_tr[c+1].eol  = (pc == w - 1);
        exp_tr[c+1].rdy  = (pr >= kh - 1) && (pc >= kw - 1);
        exp_tr[c+1+lat].ov = (pr >= kh - 1) && (pc >= kw - 1);
        exp_tr[c+1+lat].ol = (k == n - 1);
        exp_q.push_back(AW'(pc));
        if (k == n - 1) cf = c;
        k++;
      end
    end
    cd = cf + lat + 2;
    for (int c = 0; c <= cd; c++) exp_tr[c].busy = 1'b1;
    exp_tr[cd].done = 1'b1;
  endtask

  // driver: one frame on the selected instance, checked every cycle
  task automatic run_frame(input string name, input int w, input int h, input int kw,
                           input int kh, input int lat, input int mode, input int mid_start,
                           input bit restart, output int nwe, output int neol, output int nres);
    int nlast;
    logic [AW-1:0] a;
    nwe = 0; neol = 0; nres = 0; nlast = 0;
    build_model(w, h, kw, kh, lat, mode);
    @(posedge clk); #1;
    start = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    check_obs({name, "/idle_before_start"}, -1, obs, '0);
    for (int c = 0; c <= cd; c++) begin
      @(posedge clk); #1;
      start = (c == mid_start) || (restart && c == cd);
      s_valid = sv[c];
      @(negedge clk);
      check_obs(name, c, obs, exp_tr[c]);
      if (c == 0) check_int({name, "/first_state"}, int'(dbg), (kh == 1) ? int'(STREAM) : int'(FILL));
      if (obs.we) begin
        nwe++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL %s/addr_q cycle=%0d got addr=%0d want no write", name, c, obs.addr);
        end else begin
          a = exp_q.pop_front();
          check_int({name, "/addr_q"}, int'(obs.addr), int'(a));
        end
      end
      if (obs.eol) neol++;
      if (obs.ov) nres++;
      if (obs.ol) nlast++;
    end
    if (!restart) start = 1'b0;
    s_valid = 1'b0;
    check_int({name, "/writes_left"}, exp_q.size(), 0);
    check_int({name, "/results"}, nres, (w - kw + 1) * (h - kh + 1));
    check_int({name, "/lasts"}, nlast, 1);
  endtask

  task automatic idle_check(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check_obs(name, i, obs, '0);
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // reset after n accepted pixels of a continuous frame on instance A
  task automatic reset_after(input int n);
    sel = 0;
    @(posedge clk); #1;
    start = 1'b1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    s_valid = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_obs("reset_async", n, obs, '0);
    check_int("reset_async_state", int'(dbg), int'(IDLE));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_obs("reset_held", i, obs, '0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_obs("after_reset_no_done", i, obs, '0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  vec_t tbl[5];
  int   nwe, neol, nres;

  initial begin
    tbl[0] = '{mode: 0, mid_start: -1, restart: 1'b0, exp_we: 20, exp_eol: 4, exp_res: 6};
    tbl[1] = '{mode: 1, mid_start: -1, restart: 1'b0, exp_we: 20, exp_eol: 4, exp_res: 6};
    tbl[2] = '{mode: 0, mid_start: 13, restart: 1'b1, exp_we: 20, exp_eol: 4, exp_res: 6};
    tbl[3] = '{mode: 0, mid_start: -1, restart: 1'b0, exp_we: 20, exp_eol: 4, exp_res: 6};
    tbl[4] = '{mode: 2, mid_start: -1, restart: 1'b0, exp_we: 20, exp_eol: 4, exp_res: 6};

    reset = 1'b0;
    start = 1'b0;
    s_valid = 1'b0;
    sel = 0;
    repeat (3) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      @(negedge clk);
      check_obs("reset_state", s, obs, '0);
      check_int("reset_state_idle", int'(dbg), int'(IDLE));
    end
    @(posedge clk); #1;
    reset = 1'b1;

    sel = 0;
    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("a_frame%0d", i), 5, 4, 3, 3, 2, tbl[i].mode, tbl[i].mid_start,
                tbl[i].restart, nwe, neol, nres);
      check_int($sformatf("a_frame%0d/we_count", i), nwe, tbl[i].exp_we);
      check_int($sformatf("a_frame%0d/eol_count", i), neol, tbl[i].exp_eol);
      check_int($sformatf("a_frame%0d/res_count", i), nres, tbl[i].exp_res);
    end
    idle_check("a_idle", 3);

    reset_pulse();
    reset_after(12);
    run_frame("a_after_reset12", 5, 4, 3, 3, 2, 0, -1, 1'b0, nwe, neol, nres);
    check_int("a_after_reset12/res_count", nres, 6);
    reset_pulse();
    reset_after(14);
    run_frame("a_after_reset14", 5, 4, 3, 3, 2, 0, -1, 1'b0, nwe, neol, nres);
    check_int("a_after_reset14/res_count", nres, 6);

    reset_pulse();
    sel = 1;
    run_frame("b_3x3", 3, 3, 3, 3, 2, 0, -1, 1'b0, nwe, neol, nres);
    check_int("b_3x3/res_count", nres, 1);
    run_frame("b_3x3_rand", 3, 3, 3, 3, 2, 2, -1, 1'b0, nwe, neol, nres);

    reset_pulse();
    sel = 2;
    run_frame("c_4x2_k1", 4, 2, 1, 1, 1, 0, -1, 1'b0, nwe, neol, nres);
    check_int("c_4x2_k1/res_count", nres, 8);
    run_frame("c_4x2_k1_toggle", 4, 2, 1, 1, 1, 1, -1, 1'b0, nwe, neol, nres);
    idle_check("c_idle", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
